// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator.
// Holds the 640x480@60 timing defaults, pattern mode encodings and
// the eight-entry colour-bar table (1 bit per channel, {r,g,b}).
package vga_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_RAMP    = 2'd3
    } vga_mode_e;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle of the pattern generator.
//   mode                       pattern select (sink -> generator)
//   hsync, vsync               sync pulses
//   red, green, blue           pixel colour, COLOR_W bits each
//   video_on                   active-area flag
//   x, y                       pixel coordinates of the current output pixel
//   pix_en                     one-clk strobe marking a new pixel on the outputs
//   line_start, frame_start    strobes coincident with pix_en at h=0 / (0,0)
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic [1:0]         mode;
    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               video_on;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               pix_en;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  mode,
        output hsync, vsync, red, green, blue, video_on,
               x, y, pix_en, line_start, frame_start
    );

    modport slave (
        output mode,
        input  hsync, vsync, red, green, blue, video_on,
               x, y, pix_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_core.sv
// Pixel divider, h/v counters, sync generation and line/frame strobes.
//   clk, reset            system clock, async active-high reset
//   h_count, v_count      counter state of the pixel about to be emitted
//   tick                  counters advance / outputs load on this clk
//   display_area          counter state lies inside the visible area
//   line_end, frame_end   last pixel of a line / of a frame (with tick)
//   hsync..frame_start    registered outputs, one pixel behind the counters
module vga_timing_core #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int CLK_DIV   = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic           clk,
    input  logic           reset,
    output logic [X_W-1:0] h_count,
    output logic [Y_W-1:0] v_count,
    output logic           tick,
    output logic           display_area,
    output logic           line_end,
    output logic           frame_end,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pix_en,
    output logic           line_start,
    output logic           frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0]     DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [X_W-1:0] H_MAX    = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_MAX    = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_VIS    = X_W'(H_DISPLAY);
    localparam logic [Y_W-1:0] V_VIS    = Y_W'(V_DISPLAY);
    localparam logic [X_W-1:0] HS_START = X_W'(H_DISPLAY + H_FRONT);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_DISPLAY + V_FRONT);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_DISPLAY + V_FRONT + V_SYNC);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_timing_core: CLK_DIV must be in 1..16");
    end

    logic [3:0] div_cnt;
    logic       h_sync_win;
    logic       v_sync_win;
    logic       at_origin;

    // Tick on divider phase 0 so the first pixel follows reset release directly.
    assign tick         = (div_cnt == 4'd0);
    assign line_end     = tick && (h_count == H_MAX);
    assign frame_end    = line_end && (v_count == V_MAX);
    assign display_area = (h_count < H_VIS) && (v_count < V_VIS);
    assign h_sync_win   = (h_count >= HS_START) && (h_count < HS_END);
    assign v_sync_win   = (v_count >= VS_START) && (v_count < VS_END);
    assign at_origin    = (h_count == '0) && (v_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 4'd0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (tick) begin
            if (line_end) begin
                h_count <= '0;
                v_count <= (v_count == V_MAX) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
        end else begin
            pix_en      <= tick;
            line_start  <= tick && (h_count == '0);
            frame_start <= tick && at_origin;
            if (tick) begin
                video_on <= display_area;
                x        <= h_count;
                y        <= v_count;
                hsync    <= h_sync_win ? H_POL : ~H_POL;
                vsync    <= v_sync_win ? V_POL : ~V_POL;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: timing core plus mode latch, blink logic
// and pattern mux. Colour is registered on the same tick as the timing
// outputs so it stays aligned with x/y/video_on/sync.
//   clk, reset   system clock, async active-high reset
//   vga          video bundle (master side): mode in, video/sync out
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY    = H_DISPLAY_DEF,
    parameter int H_FRONT      = H_FRONT_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BACK       = H_BACK_DEF,
    parameter int V_DISPLAY    = V_DISPLAY_DEF,
    parameter int V_FRONT      = V_FRONT_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BACK       = V_BACK_DEF,
    parameter bit H_POL        = 1'b0,
    parameter bit V_POL        = 1'b0,
    parameter int CLK_DIV      = 4,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    vga_pattern_gen_if.master  vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_DISPLAY / 8;
    localparam int BAR_PW  = $clog2(BAR_W + 1);
    localparam int BF_W    = $clog2(BLINK_FRAMES + 1);
    localparam int RAMP_SH = $clog2(H_DISPLAY) - COLOR_W;

    localparam logic [BAR_PW-1:0] BAR_MAX = BAR_PW'(BAR_W - 1);
    localparam logic [BF_W-1:0]   BF_MAX  = BF_W'(BLINK_FRAMES - 1);

    if (H_DISPLAY % 8 != 0) begin : g_bad_h_display
        $error("vga_pattern_gen: H_DISPLAY must be a multiple of 8");
    end

    logic [X_W-1:0]     h_count;
    logic [Y_W-1:0]     v_count;
    logic               tick;
    logic               display_area;
    logic               line_end;
    logic               frame_end;
    logic               frame_first;
    vga_mode_e          mode_q;
    vga_mode_e          mode_eff;
    logic               blink_state;
    logic [BF_W-1:0]    frame_cnt;
    logic [BAR_PW-1:0]  bar_pix;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_c;
    logic [X_W-1:0]     ramp_full;
    logic [COLOR_W-1:0] r_n, g_n, b_n;

    vga_timing_core #(
        .H_DISPLAY (H_DISPLAY), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_DISPLAY (V_DISPLAY), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
        .H_POL     (H_POL),     .V_POL   (V_POL),   .CLK_DIV (CLK_DIV),
        .X_W       (X_W),       .Y_W     (Y_W)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .h_count      (h_count),
        .v_count      (v_count),
        .tick         (tick),
        .display_area (display_area),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .hsync        (vga.hsync),
        .vsync        (vga.vsync),
        .video_on     (vga.video_on),
        .x            (vga.x),
        .y            (vga.y),
        .pix_en       (vga.pix_en),
        .line_start   (vga.line_start),
        .frame_start  (vga.frame_start)
    );

    // The first pixel of a frame already uses the mode being latched on it.
    assign frame_first = (h_count == '0) && (v_count == '0);
    assign mode_eff    = frame_first ? vga_mode_e'(vga.mode) : mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_SOLID;
        end else if (tick && frame_first) begin
            mode_q <= vga_mode_e'(vga.mode);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_state <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == BF_MAX) begin
                frame_cnt   <= '0;
                blink_state <= ~blink_state;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Bar index tracks h_count by counting pixels within a bar, avoiding a divide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_pix <= '0;
            bar_idx <= 3'd0;
        end else if (tick) begin
            if (line_end) begin
                bar_pix <= '0;
                bar_idx <= 3'd0;
            end else if (bar_pix == BAR_MAX) begin
                bar_pix <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pix <= bar_pix + 1'b1;
            end
        end
    end

    assign bar_c     = bar_rgb(bar_idx);
    assign ramp_full = h_count >> RAMP_SH;

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (display_area) begin
            case (mode_eff)
                MODE_SOLID: begin
                    if (blink_state) r_n = '1;
                    else             g_n = '1;
                end
                MODE_BARS: begin
                    r_n = {COLOR_W{bar_c[2]}};
                    g_n = {COLOR_W{bar_c[1]}};
                    b_n = {COLOR_W{bar_c[0]}};
                end
                MODE_CHECKER: begin
                    if (h_count[5] ^ v_count[5]) begin
                        r_n = '1;
                        g_n = '1;
                        b_n = '1;
                    end
                end
                default: begin
                    r_n = ramp_full[COLOR_W-1:0];
                    g_n = ramp_full[COLOR_W-1:0];
                    b_n = ramp_full[COLOR_W-1:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga.red   <= '0;
            vga.green <= '0;
            vga.blue  <= '0;
        end else if (tick) begin
            vga.red   <= r_n;
            vga.green <= g_n;
            vga.blue  <= b_n;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 80x46 raster
// (64x40 visible) so several frames fit in a short run.
// u0: CLK_DIV=1, active-low syncs, BLINK_FRAMES=2 (walks all modes).
// u1: CLK_DIV=4, active-high syncs (divider cadence, polarity, frame spacing).
module tb_vga_pattern_gen;
    localparam int HD = 64, HF = 4, HS = 8, HB = 4;
    localparam int VD = 40, VF = 2, VS = 2, VB = 2;
    localparam int XW = 7, YW = 6, CW = 4;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t0, t1;
    int   fs1 [4];
    int   nf1 = 0;

    vga_pattern_gen_if #(.COLOR_W(CW), .X_W(XW), .Y_W(YW)) v0 ();
    vga_pattern_gen_if #(.COLOR_W(CW), .X_W(XW), .Y_W(YW)) v1 ();

    vga_pattern_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .COLOR_W(CW), .BLINK_FRAMES(2)
    ) u0 (.clk(clk), .reset(rst0), .vga(v0));

    vga_pattern_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(4), .COLOR_W(CW), .BLINK_FRAMES(60)
    ) u1 (.clk(clk), .reset(rst1), .vga(v1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v1.pix_en && v1.frame_start && nf1 < 4) begin
            fs1[nf1] <= cyc;
            nf1      <= nf1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb0(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        chk({tag, "_r"}, 32'(v0.red), 32'(r));
        chk({tag, "_g"}, 32'(v0.green), 32'(g));
        chk({tag, "_b"}, 32'(v0.blue), 32'(b));
    endtask

    // Advance to the negedge where the given unit presents pixel (px,py).
    task automatic wait_px(input int sel, input int px, input int py, input string tag);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 20000) begin
            @(negedge clk);
            n++;
            if (sel == 0) hit = v0.pix_en && (int'(v0.x) == px) && (int'(v0.y) == py);
            else          hit = v1.pix_en && (int'(v1.x) == px) && (int'(v1.y) == py);
        end
        total++;
        assert (hit) else begin
            bad++;
            $error("FAIL wait_%s observed=timeout expected=pixel(%0d,%0d)", tag, px, py);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        v0.mode = 2'd0;
        v1.mode = 2'd0;
        repeat (3) @(negedge clk);

        chk("rst_pix_en", 32'(v0.pix_en), 0);
        chk("rst_video_on", 32'(v0.video_on), 0);
        chk("rst_x", 32'(v0.x), 0);
        chk("rst_hsync_low_pol", 32'(v0.hsync), 1);
        chk("rst_vsync_low_pol", 32'(v0.vsync), 1);
        chk("rst_green", 32'(v0.green), 0);
        chk("rst_hsync_high_pol", 32'(v1.hsync), 0);
        chk("rst_vsync_high_pol", 32'(v1.vsync), 0);

        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        t0 = cyc;
        chk("first_pix_en", 32'(v0.pix_en), 1);
        chk("first_x", 32'(v0.x), 0);
        chk("first_y", 32'(v0.y), 0);
        chk("first_frame_start", 32'(v0.frame_start), 1);
        chk("first_line_start", 32'(v0.line_start), 1);
        chk_rgb0("f0_solid_green", 4'h0, 4'hF, 4'h0);
        chk("u1_first_pix_en", 32'(v1.pix_en), 1);
        @(negedge clk);
        chk("u1_pix_en_gap", 32'(v1.pix_en), 0);
        repeat (3) @(negedge clk);
        chk("u1_pix_en_period4", 32'(v1.pix_en), 1);
        chk("u1_x_after_4clk", 32'(v1.x), 1);

        wait_px(0, 63, 0, "u0_63_0");
        chk("last_visible_video_on", 32'(v0.video_on), 1);
        wait_px(0, 64, 0, "u0_64_0");
        chk("front_porch_video_on", 32'(v0.video_on), 0);
        chk_rgb0("blank_colour", 4'h0, 4'h0, 4'h0);
        wait_px(0, 67, 0, "u0_67_0");
        chk("hsync_before_window", 32'(v0.hsync), 1);
        wait_px(0, 68, 0, "u0_68_0");
        chk("hsync_window_start", 32'(v0.hsync), 0);
        wait_px(0, 75, 0, "u0_75_0");
        chk("hsync_window_end", 32'(v0.hsync), 0);
        wait_px(0, 76, 0, "u0_76_0");
        chk("hsync_after_window", 32'(v0.hsync), 1);
        wait_px(0, 0, 1, "u0_0_1");
        chk("line_start_line1", 32'(v0.line_start), 1);
        chk("no_frame_start_line1", 32'(v0.frame_start), 0);

        wait_px(1, 67, 0, "u1_67_0");
        chk("u1_hsync_before", 32'(v1.hsync), 0);
        wait_px(1, 68, 0, "u1_68_0");
        chk("u1_hsync_active_high", 32'(v1.hsync), 1);
        wait_px(1, 76, 0, "u1_76_0");
        chk("u1_hsync_after", 32'(v1.hsync), 0);

        wait_px(0, 5, 5, "u0_f0_5_5");
        chk_rgb0("f0_green", 4'h0, 4'hF, 4'h0);
        wait_px(0, 0, 40, "u0_0_40");
        chk("first_blank_line_video_on", 32'(v0.video_on), 0);
        wait_px(0, 0, 41, "u0_0_41");
        chk("vsync_before_window", 32'(v0.vsync), 1);
        wait_px(0, 0, 42, "u0_0_42");
        chk("vsync_window_start", 32'(v0.vsync), 0);
        wait_px(0, 79, 43, "u0_79_43");
        chk("vsync_window_end", 32'(v0.vsync), 0);
        wait_px(0, 0, 44, "u0_0_44");
        chk("vsync_after_window", 32'(v0.vsync), 1);

        // frame 1
        wait_px(0, 0, 0, "u0_f1");
        t1 = cyc;
        chk("frame_length_clk", 32'(t1 - t0), 3680);
        chk("f1_frame_start", 32'(v0.frame_start), 1);
        wait_px(0, 5, 5, "u0_f1_5_5");
        chk_rgb0("f1_green", 4'h0, 4'hF, 4'h0);

        // frame 2
        wait_px(0, 0, 0, "u0_f2");
        chk_rgb0("f2_red", 4'hF, 4'h0, 4'h0);

        // frame 3: mode change mid-frame must not take effect yet
        wait_px(0, 0, 0, "u0_f3");
        wait_px(0, 10, 20, "u0_f3_10_20");
        chk_rgb0("f3_red", 4'hF, 4'h0, 4'h0);
        v0.mode = 2'd1;
        wait_px(0, 30, 20, "u0_f3_30_20");
        chk_rgb0("f3_still_solid", 4'hF, 4'h0, 4'h0);

        // frame 4: colour bars
        wait_px(0, 0, 0, "u0_f4");
        chk_rgb0("bar0_white", 4'hF, 4'hF, 4'hF);
        wait_px(0, 10, 0, "u0_f4_10_0");
        chk_rgb0("bar1_yellow", 4'hF, 4'hF, 4'h0);
        wait_px(0, 40, 0, "u0_f4_40_0");
        chk_rgb0("bar5_red", 4'hF, 4'h0, 4'h0);
        wait_px(0, 63, 0, "u0_f4_63_0");
        chk_rgb0("bar7_black", 4'h0, 4'h0, 4'h0);
        chk("bar7_video_on", 32'(v0.video_on), 1);
        wait_px(0, 0, 5, "u0_f4_0_5");
        v0.mode = 2'd2;

        // frame 5: checkerboard
        wait_px(0, 0, 0, "u0_f5");
        chk_rgb0("chk_0_0_black", 4'h0, 4'h0, 4'h0);
        wait_px(0, 32, 0, "u0_f5_32_0");
        chk_rgb0("chk_32_0_white", 4'hF, 4'hF, 4'hF);
        wait_px(0, 0, 32, "u0_f5_0_32");
        chk_rgb0("chk_0_32_white", 4'hF, 4'hF, 4'hF);
        wait_px(0, 32, 32, "u0_f5_32_32");
        chk_rgb0("chk_32_32_black", 4'h0, 4'h0, 4'h0);
        v0.mode = 2'd3;

        // frame 6: grey ramp, x >> 2
        wait_px(0, 0, 0, "u0_f6");
        chk_rgb0("ramp_x0", 4'h0, 4'h0, 4'h0);
        wait_px(0, 37, 1, "u0_f6_37_1");
        chk_rgb0("ramp_x37", 4'h9, 4'h9, 4'h9);
        wait_px(0, 63, 1, "u0_f6_63_1");
        chk_rgb0("ramp_x63", 4'hF, 4'hF, 4'hF);
        v0.mode = 2'd0;

        // frame 7: solid again, blink phase red
        wait_px(0, 0, 0, "u0_f7");
        chk_rgb0("f7_red", 4'hF, 4'h0, 4'h0);
        wait_px(0, 30, 10, "u0_f7_30_10");
        rst0 = 1'b1;
        #1;
        chk("midrst_pix_en", 32'(v0.pix_en), 0);
        chk("midrst_video_on", 32'(v0.video_on), 0);
        chk("midrst_x", 32'(v0.x), 0);
        chk("midrst_y", 32'(v0.y), 0);
        chk("midrst_red", 32'(v0.red), 0);
        chk("midrst_hsync", 32'(v0.hsync), 1);
        @(negedge clk);
        chk("midrst_hold_video_on", 32'(v0.video_on), 0);
        rst0 = 1'b0;
        @(negedge clk);
        chk("post_rst_pix_en", 32'(v0.pix_en), 1);
        chk("post_rst_x", 32'(v0.x), 0);
        chk("post_rst_y", 32'(v0.y), 0);
        chk("post_rst_frame_start", 32'(v0.frame_start), 1);
        chk_rgb0("post_rst_green", 4'h0, 4'hF, 4'h0);

        wait_px(1, 0, 42, "u1_0_42");
        chk("u1_vsync_active_high", 32'(v1.vsync), 1);
        wait_px(1, 0, 44, "u1_0_44");
        chk("u1_vsync_after", 32'(v1.vsync), 0);

        begin
            int n = 0;
            while (nf1 < 3 && n < 20000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("u1_frames_seen", 32'(nf1 >= 3), 1);
        chk("u1_frame_spacing_a", 32'(fs1[1] - fs1[0]), 14720);
        chk("u1_frame_spacing_b", 32'(fs1[2] - fs1[1]), 14720);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, active pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 Parameters V_DISPLAY/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, in lines.
REQ-004 Parameters H_POL/V_POL, default 0, sync active level (0 = active-low).
REQ-005 Parameter CLK_DIV, default 4, clk cycles per pixel (1..16).
REQ-006 Parameter COLOR_W, default 4, bits per colour channel.
REQ-007 Parameter BLINK_FRAMES, default 60, frames per solid-mode colour toggle.
REQ-008 clk  in  1  system clock.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 mode  in  2  pattern select: 0 solid blink, 1 colour bars, 2 checkerboard, 3 grey ramp.
REQ-011 hsync, vsync  out  1 each  sync pulses, polarity per H_POL/V_POL.
REQ-012 red, green, blue  out  COLOR_W each  pixel colour.
REQ-013 video_on  out  1  active-area flag.
REQ-014 x, y  out  $clog2(H_TOTAL), $clog2(V_TOTAL)  current pixel coordinates.
REQ-015 pix_en  out  1  one-clk strobe per pixel.
REQ-016 line_start, frame_start  out  1  one-pix_en-wide strobes at h=0 and (h=0,v=0).

Function
REQ-017 H_TOTAL and V_TOTAL SHALL equal the sums of their four parameters.
REQ-018 Divider: pix_en SHALL pulse high every CLK_DIV clks; with CLK_DIV=1 it SHALL be constantly high.
REQ-019 h_count SHALL advance only on pix_en and wrap H_TOTAL-1 -> 0; v_count SHALL advance when h wraps and wrap V_TOTAL-1 -> 0.
REQ-020 Sync active when h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC) and likewise for v.
REQ-021 All outputs SHALL be registered, updating only on pix_en, with exactly one pixel of latency from counter state; hsync, vsync, video_on, x, y, colour SHALL stay mutually aligned.
REQ-022 Colour outputs SHALL be 0 whenever video_on is 0.
REQ-023 mode SHALL be sampled into mode_q only on the pixel with h=0,v=0; mid-frame changes SHALL take effect next frame.
REQ-024 Mode 0: full-scale red while blink_state=1, full-scale green while 0; blink_state SHALL toggle after every BLINK_FRAMES completed frames.
REQ-025 Mode 1: eight equal bars of width H_DISPLAY/8, left to right white, yellow, cyan, green, magenta, red, blue, black; bar index from a per-line counter, no divider.
REQ-026 Mode 2: 32x32 checkerboard, white when x[5]^y[5]=1, else black.
REQ-027 Mode 3: all channels = top COLOR_W bits of x scaled to H_DISPLAY (x >> ($clog2(H_DISPLAY)-COLOR_W)).
REQ-028 H_DISPLAY SHALL be a multiple of 8; otherwise elaboration SHALL fail.

Reset
REQ-029 Reset SHALL clear counters, divider, frame counter, blink_state and mode_q to 0.
REQ-030 During reset: video_on, pix_en, line_start, frame_start, x, y, colour = 0; hsync/vsync inactive (~H_POL/~V_POL).
REQ-031 Reset asserted mid-frame SHALL return the block to the reset state within the same clk; the first pixel after release SHALL be (0,0) with frame_start set.

Structure
REQ-032 Shared package vga_pkg SHALL hold the 640x480@60 timing constants, mode encodings and the 8-entry bar colour table.
REQ-033 Sub-module vga_timing_core SHALL contain divider, counters, sync and strobes; the top SHALL hold mode latch, blink logic and pattern mux.

Verification
REQ-034 CLK_DIV=1 defaults: hsync low for h 656..751 (96 pix); vsync low for lines 490..491; frame = 420000 pix.
REQ-035 CLK_DIV=4: pix_en period 4 clk; frame_start spacing 1680000 clk.
REQ-036 H_POL=V_POL=1: sync pulses high, same windows as REQ-034.
REQ-037 mode 0->1 at pixel (100,200): rest of frame solid; next frame x=80 shows yellow (F,F,0).
REQ-038 Mode 0, BLINK_FRAMES=2: frames 0-1 green, 2-3 red.
REQ-039 Reset pulse at (300,100): outputs zero next clk; after release first pixel (0,0), frame_start=1.
